// File: rtl/llc_mem_adapter_pkg.sv
// Shared constants, types and helpers for the LLC-to-memory line adapter.
// The optional statistics helper is compiled only with LLC_MEM_ADAPTER_STATS_EN.
package llc_mem_adapter_pkg;

  // Cache geometry constants
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_BITS      = 64;
  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 5;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS;
  localparam int CNT_BITS       = $clog2(WORDS_PER_LINE);

  // Cache data types
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [WORD_BITS-1:0]      word_t;
  typedef logic [1:0]                hprot_t;
  typedef logic [2:0]                hsize_t;
  typedef logic [CNT_BITS-1:0]       cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_RSP
  } state_t;

  // Request fields captured at acceptance and replayed on the command channel.
  typedef struct packed {
    logic       write;
    hsize_t     hsize;
    hprot_t     hprot;
    line_addr_t addr;
  } req_hdr_t;

`ifdef LLC_MEM_ADAPTER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

endpackage

// File: rtl/llc_mem_adapter_if.sv
// LLC request/response and memory command/beat channels of the line adapter.
// master = the adapter itself; slave = its environment (LLC core and memory).
interface llc_mem_adapter_if;
  import llc_mem_adapter_pkg::*;

  logic                 llc_mem_req_valid;
  logic                 llc_mem_req_ready;
  logic                 llc_mem_req_hwrite;
  hsize_t               llc_mem_req_hsize;
  hprot_t               llc_mem_req_hprot;
  line_addr_t           llc_mem_req_addr;
  line_t                llc_mem_req_line;

  logic                 llc_mem_rsp_valid;
  logic                 llc_mem_rsp_ready;
  line_t                llc_mem_rsp_line;

  logic                 mem_cmd_valid;
  logic                 mem_cmd_ready;
  logic                 mem_cmd_write;
  logic [ADDR_BITS-1:0] mem_cmd_addr;
  hsize_t               mem_cmd_hsize;
  hprot_t               mem_cmd_hprot;

  logic                 mem_wdata_valid;
  logic                 mem_wdata_ready;
  word_t                mem_wdata;
  logic                 mem_wdata_last;

  logic                 mem_rdata_valid;
  logic                 mem_rdata_ready;
  word_t                mem_rdata;
  logic                 mem_rdata_last;

  modport master (
    input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
           llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
           mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata, mem_rdata_last,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hsize, mem_cmd_hprot,
           mem_wdata_valid, mem_wdata, mem_wdata_last, mem_rdata_ready
  );

  modport slave (
    output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
           llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
           mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata, mem_rdata_last,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hsize, mem_cmd_hprot,
           mem_wdata_valid, mem_wdata, mem_wdata_last, mem_rdata_ready
  );

endinterface

// File: rtl/llc_mem_line_buf.sv
// Line buffer for the adapter: whole-line load, per-word write decode and
// word-select mux, both indexed by the adapter's beat counter.
module llc_mem_line_buf
  import llc_mem_adapter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_en,
  input  line_t load_line,
  input  logic  wr_en,
  input  cnt_t  idx,
  input  word_t wr_word,
  output word_t rd_word,
  output line_t line
);

  line_t line_q;

  // NOTE: the line register is reset rather than left unknown because it is
  // visible on the response port and unwritten words must read back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (wr_en) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (idx == cnt_t'(w)) line_q[w*WORD_BITS +: WORD_BITS] <= wr_word;
      end
    end
  end

  assign rd_word = line_q[idx*WORD_BITS +: WORD_BITS];
  assign line    = line_q;

endmodule

// File: rtl/llc_mem_adapter.sv
// Converts one whole-line LLC memory request into a command plus word beats and
// assembles read beats into a line response. Optional counters: LLC_MEM_ADAPTER_STATS_EN.
module llc_mem_adapter
  import llc_mem_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  llc_mem_adapter_if.master  bus
`ifdef LLC_MEM_ADAPTER_STATS_EN
  ,
  output logic [15:0]        stat_rd_cnt,
  output logic [15:0]        stat_wr_cnt,
  output logic [15:0]        stat_stall_cnt
`endif
);

  state_t   state;
  cnt_t     cnt;
  req_hdr_t hdr;
  logic     req_ready_q;
  logic     cmd_valid_q;
  logic     wdata_valid_q;
  logic     rdata_ready_q;
  logic     rsp_valid_q;

  logic     req_fire;
  logic     rdata_fire;
  line_t    load_line;
  line_t    buf_line;
  word_t    buf_word;

  assign req_fire   = req_ready_q && bus.llc_mem_req_valid;
  assign rdata_fire = rdata_ready_q && bus.mem_rdata_valid;
  // Reads load zeros so a short burst leaves the untouched words cleared.
  assign load_line  = bus.llc_mem_req_hwrite ? bus.llc_mem_req_line : '0;

  llc_mem_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (req_fire),
    .load_line (load_line),
    .wr_en     (rdata_fire),
    .idx       (cnt),
    .wr_word   (bus.mem_rdata),
    .rd_word   (buf_word),
    .line      (buf_line)
  );

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hdr           <= '0;
      req_ready_q   <= 1'b1;
      cmd_valid_q   <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_fire) begin
            hdr.write   <= bus.llc_mem_req_hwrite;
            hdr.hsize   <= bus.llc_mem_req_hsize;
            hdr.hprot   <= bus.llc_mem_req_hprot;
            hdr.addr    <= bus.llc_mem_req_addr;
            req_ready_q <= 1'b0;
            cmd_valid_q <= 1'b1;
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cnt         <= '0;
            if (hdr.write) begin
              wdata_valid_q <= 1'b1;
              state         <= ST_WDATA;
            end else begin
              rdata_ready_q <= 1'b1;
              state         <= ST_RDATA;
            end
          end
        end
        ST_WDATA: begin
          if (bus.mem_wdata_ready) begin
            if (cnt == CNT_MAX) begin
              wdata_valid_q <= 1'b0;
              req_ready_q   <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
        end
        ST_RDATA: begin
          if (bus.mem_rdata_valid) begin
            // Saturate so surplus beats keep landing in the top word.
            if (cnt != CNT_MAX) cnt <= cnt + cnt_t'(1);
            if (bus.mem_rdata_last) begin
              rdata_ready_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state         <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          if (bus.llc_mem_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          req_ready_q   <= 1'b1;
          cmd_valid_q   <= 1'b0;
          wdata_valid_q <= 1'b0;
          rdata_ready_q <= 1'b0;
          rsp_valid_q   <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.llc_mem_req_ready = req_ready_q;
  assign bus.llc_mem_rsp_valid = rsp_valid_q;
  assign bus.llc_mem_rsp_line  = buf_line;

  assign bus.mem_cmd_valid     = cmd_valid_q;
  assign bus.mem_cmd_write     = hdr.write;
  assign bus.mem_cmd_addr      = {hdr.addr, {OFFSET_BITS{1'b0}}};
  assign bus.mem_cmd_hsize     = hdr.hsize;
  assign bus.mem_cmd_hprot     = hdr.hprot;

  assign bus.mem_wdata_valid   = wdata_valid_q;
  assign bus.mem_wdata         = buf_word;
  assign bus.mem_wdata_last    = wdata_valid_q && (cnt == CNT_MAX);

  assign bus.mem_rdata_ready   = rdata_ready_q;

`ifdef LLC_MEM_ADAPTER_STATS_EN
  logic        rd_done;
  logic        wr_done;
  logic        stall;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  logic [15:0] stall_cnt_q;

  assign rd_done = rsp_valid_q && bus.llc_mem_rsp_ready;
  assign wr_done = wdata_valid_q && bus.mem_wdata_ready && (cnt == CNT_MAX);
  assign stall   = (cmd_valid_q && !bus.mem_cmd_ready) ||
                   (wdata_valid_q && !bus.mem_wdata_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_done) rd_cnt_q    <= sat_inc(rd_cnt_q);
      if (wr_done) wr_cnt_q    <= sat_inc(wr_cnt_q);
      if (stall)   stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_llc_mem_adapter.sv
// Directed self-checking bench for llc_mem_adapter: reads, writes, stalls,
// short/long bursts, mid-transfer reset and (with the stats macro) counters.
module tb_llc_mem_adapter;
  import llc_mem_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_mem_adapter_if bus ();

`ifdef LLC_MEM_ADAPTER_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

  llc_mem_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LLC_MEM_ADAPTER_STATS_EN
    ,
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc      = 0;
  int     acc_cyc  = 0;
  hsize_t exp_hsize;
  hprot_t exp_hprot;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_hsize  = '0;
    bus.llc_mem_req_hprot  = '0;
    bus.llc_mem_req_addr   = '0;
    bus.llc_mem_req_line   = '0;
    bus.llc_mem_rsp_ready  = 1'b0;
    bus.mem_cmd_ready      = 1'b0;
    bus.mem_wdata_ready    = 1'b0;
    bus.mem_rdata_valid    = 1'b0;
    bus.mem_rdata          = '0;
    bus.mem_rdata_last     = 1'b0;
  endtask

  // Presents a request and returns in the cycle after acceptance (CMD state).
  task automatic issue_req(input logic wr, input line_addr_t a, input line_t l,
                           input hsize_t sz, input hprot_t pr);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = wr;
    bus.llc_mem_req_addr   = a;
    bus.llc_mem_req_line   = l;
    bus.llc_mem_req_hsize  = sz;
    bus.llc_mem_req_hprot  = pr;
    exp_hsize = sz;
    exp_hprot = pr;
    for (int i = 0; i < 20 && !bus.llc_mem_req_ready; i++) step();
    check("req_accept_ready", bus.llc_mem_req_ready, 1'b1);
    acc_cyc = cyc;
    step();
    bus.llc_mem_req_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] exp_addr, input int stall);
    for (int i = 0; i < stall; i++) begin
      check("cmd_valid_stalled", bus.mem_cmd_valid, 1'b1);
      check("cmd_addr_stalled", bus.mem_cmd_addr, exp_addr);
      step();
    end
    check("cmd_valid", bus.mem_cmd_valid, 1'b1);
    check("cmd_write", bus.mem_cmd_write, wr);
    check("cmd_addr", bus.mem_cmd_addr, exp_addr);
    check("cmd_hsize", bus.mem_cmd_hsize, exp_hsize);
    check("cmd_hprot", bus.mem_cmd_hprot, exp_hprot);
    bus.mem_cmd_ready = 1'b1;
    step();
    bus.mem_cmd_ready = 1'b0;
    check("cmd_valid_drop", bus.mem_cmd_valid, 1'b0);
  endtask

  // Beats base, base+1, ... back-to-back; last flagged on beat n.
  task automatic read_beats(input word_t base, input int n);
    check("rdata_ready", bus.mem_rdata_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      check("rsp_valid_early", bus.llc_mem_rsp_valid, 1'b0);
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = base + word_t'(i);
      bus.mem_rdata_last  = (i == n - 1);
      step();
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata_last  = 1'b0;
  endtask

  task automatic take_rsp();
    bus.llc_mem_rsp_ready = 1'b1;
    step();
    bus.llc_mem_rsp_ready = 1'b0;
    check("rsp_valid_after_hs", bus.llc_mem_rsp_valid, 1'b0);
    check("req_ready_after_rsp", bus.llc_mem_req_ready, 1'b1);
  endtask

  task automatic write_beats_fast(input word_t base);
    bus.mem_wdata_ready = 1'b1;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      check("wfast_valid", bus.mem_wdata_valid, 1'b1);
      check("wfast_data", bus.mem_wdata, base + word_t'(i));
      step();
    end
    bus.mem_wdata_ready = 1'b0;
    check("wfast_done", bus.mem_wdata_valid, 1'b0);
  endtask

  initial begin
    int idx;
    idle_inputs();
    #22 rst = 1'b1;
    #1;

    // Reset state
    check("rst_req_ready", bus.llc_mem_req_ready, 1'b1);
    check("rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
    check("rst_wdata_valid", bus.mem_wdata_valid, 1'b0);
    check("rst_rdata_ready", bus.mem_rdata_ready, 1'b0);
    check("rst_rsp_valid", bus.llc_mem_rsp_valid, 1'b0);
    check("rst_rsp_line", bus.llc_mem_rsp_line, 256'h0);

    // 1: read, no stalls, latency and address mapping
    issue_req(1'b0, 27'h0123456, '0, 3'b011, 2'b10);
    check("t1_req_ready_busy", bus.llc_mem_req_ready, 1'b0);
    do_cmd(1'b0, 32'h02468AC0, 0);
    read_beats(64'hA0, 4);
    check("t1_rsp_valid", bus.llc_mem_rsp_valid, 1'b1);
    check("t1_latency", cyc - acc_cyc, 6);
    check("t1_line", bus.llc_mem_rsp_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    take_rsp();

    // 2: write with wdata_ready toggling 1,0,1,0,...
    issue_req(1'b1, 27'h0000ABC, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 3'b011, 2'b01);
    do_cmd(1'b1, 32'h00015780, 2);
    idx = 0;
    for (int k = 0; k < 8 && idx < 4; k++) begin
      bus.mem_wdata_ready = (k % 2 == 0);
      check("t2_wvalid", bus.mem_wdata_valid, 1'b1);
      check("t2_wdata", bus.mem_wdata, 64'hD0 + 64'(idx));
      check("t2_wlast", bus.mem_wdata_last, idx == 3);
      check("t2_no_rsp", bus.llc_mem_rsp_valid, 1'b0);
      step();
      if (k % 2 == 0) idx++;
    end
    bus.mem_wdata_ready = 1'b0;
    check("t2_wvalid_done", bus.mem_wdata_valid, 1'b0);
    check("t2_req_ready", bus.llc_mem_req_ready, 1'b1);
    check("t2_no_rsp_end", bus.llc_mem_rsp_valid, 1'b0);

    // 3: response back-pressure for 10 cycles with a second request waiting
    issue_req(1'b0, 27'h0000010, '0, 3'b010, 2'b11);
    do_cmd(1'b0, 32'h00000200, 0);
    read_beats(64'hC0, 4);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_addr   = 27'h7FFFFFF;
    for (int k = 0; k < 10; k++) begin
      check("t3_rsp_valid_hold", bus.llc_mem_rsp_valid, 1'b1);
      check("t3_line_hold", bus.llc_mem_rsp_line, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
      check("t3_req_blocked", bus.llc_mem_req_ready, 1'b0);
      check("t3_no_cmd", bus.mem_cmd_valid, 1'b0);
      step();
    end
    take_rsp();

    // 4a: the waiting request at the top line address, short burst
    issue_req(1'b0, 27'h7FFFFFF, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'hFFFFFFE0, 0);
    read_beats(64'hB0, 3);
    check("t4a_rsp_valid", bus.llc_mem_rsp_valid, 1'b1);
    check("t4a_line", bus.llc_mem_rsp_line, {64'h0, 64'hB2, 64'hB1, 64'hB0});
    take_rsp();

    // 4b: long burst, extra beats overwrite the top word
    issue_req(1'b0, 27'h0000001, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'h00000020, 0);
    read_beats(64'hE0, 6);
    check("t4b_line", bus.llc_mem_rsp_line, {64'hE5, 64'hE2, 64'hE1, 64'hE0});
    take_rsp();

    // 5: reset during the read data phase
    issue_req(1'b0, 27'h0000055, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'h00000AA0, 0);
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 64'h99;
    step();
    bus.mem_rdata = 64'h9A;
    #2 rst = 1'b0;
    #1;
    check("t5_cmd_valid", bus.mem_cmd_valid, 1'b0);
    check("t5_wdata_valid", bus.mem_wdata_valid, 1'b0);
    check("t5_rdata_ready", bus.mem_rdata_ready, 1'b0);
    check("t5_rsp_valid", bus.llc_mem_rsp_valid, 1'b0);
    check("t5_line_cleared", bus.llc_mem_rsp_line, 256'h0);
    idle_inputs();
    #3 rst = 1'b1;
    step();
    check("t5_req_ready", bus.llc_mem_req_ready, 1'b1);
    check("t5_no_rsp", bus.llc_mem_rsp_valid, 1'b0);
`ifdef LLC_MEM_ADAPTER_STATS_EN
    check("t6_rd_reset", stat_rd_cnt, 16'd0);
    check("t6_stall_reset", stat_stall_cnt, 16'd0);
`endif
    issue_req(1'b0, 27'h0000002, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'h00000040, 0);
    read_beats(64'hF0, 4);
    check("t5_line", bus.llc_mem_rsp_line, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
    take_rsp();

`ifdef LLC_MEM_ADAPTER_STATS_EN
    // 6: statistics; the read above is the first since reset
    issue_req(1'b1, 27'h0000003, {64'h13, 64'h12, 64'h11, 64'h10}, 3'b011, 2'b00);
    do_cmd(1'b1, 32'h00000060, 2);
    write_beats_fast(64'h10);
    issue_req(1'b0, 27'h0000004, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'h00000080, 1);
    read_beats(64'h20, 4);
    take_rsp();
    issue_req(1'b1, 27'h0000005, {64'h33, 64'h32, 64'h31, 64'h30}, 3'b011, 2'b00);
    do_cmd(1'b1, 32'h000000A0, 1);
    write_beats_fast(64'h30);
    issue_req(1'b0, 27'h0000006, '0, 3'b011, 2'b00);
    do_cmd(1'b0, 32'h000000C0, 0);
    read_beats(64'h40, 4);
    take_rsp();
    check("t6_rd_cnt", stat_rd_cnt, 16'd3);
    check("t6_wr_cnt", stat_wr_cnt, 16'd2);
    check("t6_stall_cnt", stat_stall_cnt, 16'd4);

    issue_req(1'b0, 27'h0000007, '0, 3'b011, 2'b00);
    repeat (65540) step();
    do_cmd(1'b0, 32'h000000E0, 0);
    read_beats(64'h50, 4);
    take_rsp();
    check("t6_stall_sat", stat_stall_cnt, 16'hFFFF);
    check("t6_rd_cnt_after", stat_rd_cnt, 16'd4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
